// File: rtl/div_unit_pkg.sv
// Shared execute-stage definitions used by the iterative divider.
package div_unit_pkg;

    localparam int         ALUOP_MEXT_BIT = 6;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    // Quotient returned on divide-by-zero; sliced down to XLEN by users.
    localparam logic [63:0] DIV_ZERO_Q = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FIX,
        S_DONE
    } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division step: shift {rem,quo} left, subtract if it fits.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] rem_sh;
    logic [XLEN:0] trial;
    logic          unused_rem_msb;

    // The partial remainder is always below the divisor, so its top bit is
    // known zero and drops out of the shift.
    assign unused_rem_msb = rem_in[XLEN];
    assign rem_sh         = {rem_in[XLEN-1:0], quo_in[XLEN-1]};
    assign trial          = rem_sh - {1'b0, divisor};

    // Keep the trial difference when it did not borrow and record a 1 bit.
    always_comb begin
        rem_out = rem_sh;
        quo_out = {quo_in[XLEN-2:0], 1'b0};
        if (!trial[XLEN]) begin
            rem_out    = trial;
            quo_out[0] = 1'b1;
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU) with valid/ready ports.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [10:0]     aluop,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero_division,
    output logic            overflow_signed_div
);

    localparam int              CW      = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state;
    logic [CW-1:0]   cnt;
    logic [XLEN:0]   rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] divisor;
    logic [2:0]      f3;
    logic            is_signed;
    logic            sign_a;
    logic            sign_b;
    logic            spec_zd;
    logic            spec_ov;

    logic [XLEN:0]   rem_nx;
    logic [XLEN-1:0] quo_nx;
    logic            take;
    logic            op_signed;
    logic            a_neg;
    logic            b_neg;
    logic            is_zd;
    logic            is_ov;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic            unused_aluop;

    assign unused_aluop = ^{aluop[10:7], aluop[5:3]};

    assign take      = (state == S_IDLE) && in_valid && !flush
                       && aluop[ALUOP_MEXT_BIT] && aluop[2];
    assign op_signed = !aluop[0];
    assign a_neg     = op_signed && a[XLEN-1];
    assign b_neg     = op_signed && b[XLEN-1];
    // |MIN_NEG| wraps to itself and is then treated as unsigned.
    assign abs_a     = a_neg ? -a : a;
    assign abs_b     = b_neg ? -b : b;
    assign is_zd     = (b == '0);
    assign is_ov     = op_signed && (a == MIN_NEG) && (b == '1);

    // Special-case results are preloaded already corrected, so bypass fix-up.
    assign q_fix = (is_signed && (sign_a ^ sign_b) && !(spec_zd || spec_ov))
                   ? -quo : quo;
    assign r_fix = (is_signed && sign_a && !(spec_zd || spec_ov))
                   ? -rem[XLEN-1:0] : rem[XLEN-1:0];

    div_step #(.XLEN(XLEN)) u_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .divisor (divisor),
        .rem_out (rem_nx),
        .quo_out (quo_nx)
    );

    // Control FSM plus datapath registers; all outputs are registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state               <= S_IDLE;
            cnt                 <= '0;
            rem                 <= '0;
            quo                 <= '0;
            divisor             <= '0;
            f3                  <= '0;
            is_signed           <= 1'b0;
            sign_a              <= 1'b0;
            sign_b              <= 1'b0;
            spec_zd             <= 1'b0;
            spec_ov             <= 1'b0;
            in_ready            <= 1'b1;
            out_valid           <= 1'b0;
            result              <= '0;
            zero_division       <= 1'b0;
            overflow_signed_div <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (take) begin
                        f3        <= aluop[2:0];
                        is_signed <= op_signed;
                        sign_a    <= a_neg;
                        sign_b    <= b_neg;
                        spec_zd   <= is_zd;
                        spec_ov   <= is_ov;
                        in_ready  <= 1'b0;
                        // Special cases skip the iterations and take one
                        // pass through FIX, so DONE lands on the next edge.
                        if (is_zd) begin
                            quo   <= DIV_ZERO_Q[XLEN-1:0];
                            rem   <= {1'b0, a};
                            state <= S_FIX;
                        end else if (is_ov) begin
                            quo   <= MIN_NEG;
                            rem   <= '0;
                            state <= S_FIX;
                        end else begin
                            quo     <= abs_a;
                            divisor <= abs_b;
                            rem     <= '0;
                            cnt     <= CW'(XLEN - 1);
                            state   <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        state    <= S_IDLE;
                        in_ready <= 1'b1;
                    end else begin
                        rem <= rem_nx;
                        quo <= quo_nx;
                        cnt <= cnt - 1'b1;
                        if (cnt == '0) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        state    <= S_IDLE;
                        in_ready <= 1'b1;
                    end else begin
                        result              <= f3[1] ? r_fix : q_fix;
                        zero_division       <= spec_zd;
                        overflow_signed_div <= spec_ov;
                        out_valid           <= 1'b1;
                        state               <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Transfer or kill: either way nothing new is taken
                    // this cycle and in_ready returns on the next.
                    if (flush || out_ready) begin
                        out_valid           <= 1'b0;
                        zero_division       <= 1'b0;
                        overflow_signed_div <= 1'b0;
                        in_ready            <= 1'b1;
                        state               <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table, corner sequences, random.
module tb_div_unit;
    import div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] aluop;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero_division;
    logic        overflow_signed_div;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zd;
        logic        ov;
        int          lat;
    } vec_t;

    div_unit #(.XLEN(32)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .aluop               (aluop),
        .a                   (a),
        .b                   (b),
        .flush               (flush),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .result              (result),
        .zero_division       (zero_division),
        .overflow_signed_div (overflow_signed_div)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: RV32M rules with plain 64-bit integer arithmetic.
    function automatic void model(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] r, output logic zd, output logic ov,
                                  output int lat);
        longint sa, sb, ua, ub, q, m;
        zd = 1'b0; ov = 1'b0; lat = 33;
        if (bv == 32'h0) begin
            zd = 1'b1; lat = 1;
            r  = f3[1] ? av : 32'hFFFF_FFFF;
        end else if (!f3[0] && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
            ov = 1'b1; lat = 1;
            r  = f3[1] ? 32'h0 : 32'h8000_0000;
        end else if (!f3[0]) begin
            sa = $signed(av); sb = $signed(bv);
            q  = sa / sb; m = sa % sb;
            r  = f3[1] ? m[31:0] : q[31:0];
        end else begin
            ua = {32'h0, av}; ub = {32'h0, bv};
            q  = ua / ub; m = ua % ub;
            r  = f3[1] ? m[31:0] : q[31:0];
        end
    endfunction

    // Offer one M-extension op, measure edges from acceptance to out_valid.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv,
                          input bit take_result, output logic [31:0] r, output logic zd,
                          output logic ov, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("in_ready_before_op", in_ready, 1);
        aluop    = 11'h040 | {8'h0, f3};
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r  = result;
        zd = zero_division;
        ov = overflow_signed_div;
        if (take_result) begin
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
    endtask

    task automatic watch_none(input string name, input int n);
        bit seen;
        seen = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk(name, 32'(seen), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [12];
        logic [31:0] r, er;
        logic        zd, ov, ezd, eov;
        int          lat, elat;

        tbl[0]  = '{F3_DIVU, 32'd100,        32'd7,          32'h0000_000E, 1'b0, 1'b0, 33};
        tbl[1]  = '{F3_REMU, 32'd100,        32'd7,          32'h0000_0002, 1'b0, 1'b0, 33};
        tbl[2]  = '{F3_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 1'b0, 1'b0, 33};
        tbl[3]  = '{F3_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 1'b0, 1'b0, 33};
        tbl[4]  = '{F3_REM,  32'd7,          32'hFFFF_FFFE,  32'h0000_0001, 1'b0, 1'b0, 33};
        tbl[5]  = '{F3_DIVU, 32'h1234_5678,  32'h0,          32'hFFFF_FFFF, 1'b1, 1'b0, 1};
        tbl[6]  = '{F3_REMU, 32'h1234_5678,  32'h0,          32'h1234_5678, 1'b1, 1'b0, 1};
        tbl[7]  = '{F3_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1'b0, 1'b1, 1};
        tbl[8]  = '{F3_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 1'b0, 1'b1, 1};
        tbl[9]  = '{F3_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 1'b0, 1'b0, 33};
        tbl[10] = '{F3_DIV,  32'hFFFF_FFF9,  32'h0,          32'hFFFF_FFFF, 1'b1, 1'b0, 1};
        tbl[11] = '{F3_REM,  32'hFFFF_FFF9,  32'h0,          32'hFFFF_FFF9, 1'b1, 1'b0, 1};

        rst_n = 1'b0; in_valid = 1'b0; aluop = '0; a = '0; b = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {zero_division, overflow_signed_div}, 0);
        @(negedge clk) rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].f3, tbl[i].a, tbl[i].b, 1'b1, r, zd, ov, lat);
            chk($sformatf("vec%0d_result", i), r, tbl[i].res);
            chk($sformatf("vec%0d_zd", i), zd, tbl[i].zd);
            chk($sformatf("vec%0d_ov", i), ov, tbl[i].ov);
            chk($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
        end

        // Backpressure: result and flags hold while out_ready stays low
        run_op(F3_REMU, 32'h1234_5678, 32'h0, 1'b0, r, zd, ov, lat);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_result", result, 32'h1234_5678);
            chk("bp_zd", zero_division, 1);
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("xfer_in_ready", in_ready, 1);
        chk("xfer_out_valid", out_valid, 0);
        chk("xfer_zd_clear", zero_division, 0);

        // Non-divide opcodes are ignored (M bit clear, then funct3[2] clear)
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            aluop = (k == 0) ? 11'h004 : 11'h041;
            a = 32'd100; b = 32'd7; in_valid = 1'b1;
            repeat (2) @(posedge clk);
            #1 in_valid = 1'b0;
            chk($sformatf("nonm%0d_in_ready", k), in_ready, 1);
            watch_none($sformatf("nonm%0d_no_valid", k), 40);
        end

        // Flush in IDLE blocks a simultaneous offer
        @(negedge clk);
        aluop = 11'h040 | {8'h0, F3_DIVU}; a = 32'd100; b = 32'd7;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        chk("idle_flush_in_ready", in_ready, 1);
        watch_none("idle_flush_no_valid", 40);

        // Flush mid-BUSY
        @(negedge clk);
        aluop = 11'h040 | {8'h0, F3_DIVU}; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_in_ready", in_ready, 1);
        chk("flush_out_valid", out_valid, 0);
        watch_none("flush_no_valid", 40);
        run_op(F3_DIVU, 32'd100, 32'd7, 1'b1, r, zd, ov, lat);
        chk("post_flush_result", r, 32'h0000_000E);
        chk("post_flush_latency", lat, 33);

        // Reset mid-BUSY
        @(negedge clk);
        aluop = 11'h040 | {8'h0, F3_DIV}; a = 32'hFFFF_FFF9; b = 32'd2; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_result", result, 0);
        chk("midrst_flags", {zero_division, overflow_signed_div}, 0);
        watch_none("midrst_no_valid", 40);
        run_op(F3_DIVU, 32'd100, 32'd7, 1'b1, r, zd, ov, lat);
        chk("post_rst_result", r, 32'h0000_000E);
        chk("post_rst_latency", lat, 33);

        // Randomized operations against the reference model
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  f3;
            logic [31:0] ra, rb;
            int          mode;
            f3   = 3'(4 + $urandom_range(0, 3));
            ra   = $urandom;
            rb   = $urandom;
            mode = $urandom_range(0, 9);
            if (mode == 0) rb = 32'h0;
            else if (mode == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (mode == 2) rb = 32'($urandom_range(1, 15));
            else if (mode == 3) ra = 32'($urandom_range(0, 15));
            model(f3, ra, rb, er, ezd, eov, elat);
            run_op(f3, ra, rb, 1'b1, r, zd, ov, lat);
            chk($sformatf("rnd%0d_f3=%0d_%h_%h_result", i, f3, ra, rb), r, er);
            chk($sformatf("rnd%0d_zd", i), zd, ezd);
            chk($sformatf("rnd%0d_ov", i), ov, eov);
            chk($sformatf("rnd%0d_latency", i), lat, elat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
